dmem_responder: RTL and testbench

- Data-memory responder: the slave end of the load/store request channel issued by the LSU.
- Accepts one request at a time over a valid/ready handshake and performs the word read or byte-masked write on internal storage.
- Returns the response after a programmable latency, replacing the zero-wait combinational SRAM so the LSU can be exercised against multi-cycle memory.

---
 rtl/dmem_responder_if.sv | 24 ++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Load/store request/response channel between the LSU (master) and the
// data-memory responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_wen;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the LSU load/store channel.
// Accepts one request at a time, performs a word read or byte-masked write
// on internal storage and returns the response after a programmable latency.
//
// Optional build macro DMEM_RAND_DELAY_EN: adds an 8-bit LFSR whose two low
// bits are added to LATENCY at each acceptance to jitter response timing.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | req_ready=1, waiting for a request handshake
// WAIT    | request done on storage, counting down the latency
// RESP    | resp_valid=1, holding response until resp_ready
module dmem_responder #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned LATENCY   = 2
) (
    input  logic clk,
    input  logic rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Wide enough for LATENCY plus the largest random extra delay (3).
    localparam int unsigned CW = $clog2(LATENCY + 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;

    logic [31:0]   mem [DEPTH];

    logic [31:0]   offset;
    logic [31:0]   word_idx;
    logic [IW-1:0] mem_idx;
    logic          addr_err;
    logic          accept;
    logic [CW-1:0] eff_lat;

    // Address decode: word index relative to BASE_ADDR, low two bits dropped.
    always_comb begin
        offset   = bus.req_addr - BASE_ADDR;
        word_idx = offset >> 2;
        addr_err = (bus.req_addr < BASE_ADDR) || (word_idx >= 32'(DEPTH));
        mem_idx  = word_idx[IW-1:0];
        accept   = bus.req_valid && req_ready_q;
    end

`ifdef DMEM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4, free-running every cycle.
    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        eff_lat = CW'(LATENCY) + CW'(lfsr_q[1:0]);
    end

    // LFSR state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    // Fixed latency build.
    always_comb begin
        eff_lat = CW'(LATENCY);
    end
`endif

    // Next-state and next-output logic for the request/response sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready_d  = 1'b0;
                    resp_err_d   = addr_err;
                    resp_rdata_d = (bus.req_wen || addr_err) ? 32'h0 : mem[mem_idx];
                    if (eff_lat == '0) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        cnt_d        = '0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = eff_lat;
                    end
                end
            end
            ST_WAIT: begin
                // A zero count here is unreachable; treat it like the last tick.
                if (cnt_q <= CW'(1)) begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_d        = '0;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    // Sequencer registers; reset drops any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Byte-masked storage write at the acceptance edge; storage is not reset.
    always_ff @(posedge clk) begin
        if (!rst && accept && bus.req_wen && !addr_err) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.req_wmask[i]) begin
                    mem[mem_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, random
// traffic against a word-array reference model, reset abort and a
// zero-latency back-to-back instance.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int unsigned LAT   = 2;

    logic clk = 1'b0;
    logic rst;
    logic rst0;

    always #5 clk = ~clk;

    dmem_responder_if bus ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(0)) u_dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          hold;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a flat word array indexed by byte offset / 4.
    function automatic void model_access(input logic [31:0] addr, input logic wen,
                                         input logic [31:0] wdata, input logic [3:0] wmask,
                                         output logic [31:0] rd, output logic er);
        longint a;
        longint lo;
        longint hi;
        int     idx;
        a  = longint'(addr);
        lo = longint'(BASE);
        hi = lo + 4 * longint'(DEPTH);
        er = (a < lo) || (a >= hi);
        rd = 32'h0;
        if (!er) begin
            idx = int'((a - lo) / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (wmask[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            end else begin
                rd = model_mem[idx];
            end
        end
    endfunction

    task automatic junk_req();
        bus.req_valid = 1'($urandom_range(0, 1));
        bus.req_addr  = $urandom;
        bus.req_wen   = 1'($urandom_range(0, 1));
        bus.req_wdata = $urandom;
        bus.req_wmask = 4'($urandom_range(0, 15));
    endtask

    // One full transaction on the LATENCY=LAT instance; entered and left at a negedge.
    task automatic txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold,
                       input logic [31:0] exp_rd, input logic exp_er);
        int k;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.req_wen    = wen;
        bus.req_wdata  = wdata;
        bus.req_wmask  = wmask;
        bus.resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        junk_req();
        k = 1;
        while (bus.resp_valid !== 1'b1 && k < 40) begin
            check("wait_req_ready_low", 32'(bus.req_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            junk_req();
            k++;
        end
        check("resp_latency", 32'(k), 32'(LAT + 1));
        for (int h = 0; h < hold; h++) begin
            check("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
            check("hold_rdata", bus.resp_rdata, exp_rd);
            check("hold_err", 32'(bus.resp_err), 32'(exp_er));
            @(posedge clk);
            @(negedge clk);
            junk_req();
        end
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_rdata", bus.resp_rdata, exp_rd);
        check("resp_err", 32'(bus.resp_err), 32'(exp_er));
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        check("post_hs_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("post_hs_req_ready", 32'(bus.req_ready), 32'd1);
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                input logic [3:0] wmask, input int hold,
                                input logic [31:0] exp_rd, input logic exp_er);
        vec_t v;
        v.addr = addr; v.wen = wen; v.wdata = wdata; v.wmask = wmask;
        v.hold = hold; v.exp_rd = exp_rd; v.exp_er = exp_er;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m_rd;
        logic        m_er;
        logic [31:0] a;
        logic [31:0] d;
        logic        w;
        logic [3:0]  m;
        int          r;

        vecs.push_back(mk(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0));
        vecs.push_back(mk(32'h8000_0011, 1'b1, 32'h0000_5500, 4'h2, 1, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_55EF, 1'b0));
        vecs.push_back(mk(32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1));
        vecs.push_back(mk(32'h8000_1000, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1));
        vecs.push_back(mk(32'h8000_0000, 1'b1, 32'h1122_3344, 4'hF, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_1000, 1'b1, 32'hFFFF_FFFF, 4'hF, 0, 32'h0,         1'b1));
        vecs.push_back(mk(32'h8000_0000, 1'b0, 32'h0,         4'h0, 0, 32'h1122_3344, 1'b0));
        vecs.push_back(mk(32'h8000_0013, 1'b0, 32'h0,         4'h0, 5, 32'hDEAD_55EF, 1'b0));
        vecs.push_back(mk(32'h8000_0010, 1'b1, 32'h1234_5678, 4'h9, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0012, 1'b0, 32'h0,         4'h0, 2, 32'h12AD_5578, 1'b0));
        vecs.push_back(mk(32'h8000_0008, 1'b1, 32'h0102_0304, 4'hF, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0008, 1'b1, 32'hAABB_CCDD, 4'h0, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0008, 1'b0, 32'h0,         4'h0, 0, 32'h0102_0304, 1'b0));
        vecs.push_back(mk(32'h8000_0FFC, 1'b1, 32'h5A5A_5A5A, 4'hF, 0, 32'h0,         1'b0));
        vecs.push_back(mk(32'h8000_0FFC, 1'b0, 32'h0,         4'h0, 0, 32'h5A5A_5A5A, 1'b0));
        vecs.push_back(mk(32'hFFFF_FFFC, 1'b1, 32'h0,         4'hF, 0, 32'h0,         1'b1));
        vecs.push_back(mk(32'h0000_0000, 1'b0, 32'h0,         4'h0, 0, 32'h0,         1'b1));
        vecs.push_back(mk(32'h7FFF_FFFF, 1'b0, 32'h0,         4'h0, 3, 32'h0,         1'b1));

        bus.req_valid  = 1'b0;  bus.req_addr  = 32'h0; bus.req_wen = 1'b0;
        bus.req_wdata  = 32'h0; bus.req_wmask = 4'h0;  bus.resp_ready = 1'b0;
        bus0.req_valid = 1'b0;  bus0.req_addr = 32'h0; bus0.req_wen = 1'b0;
        bus0.req_wdata = 32'h0; bus0.req_wmask = 4'h0; bus0.resp_ready = 1'b1;
        rst  = 1'b1;
        rst0 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        rst  = 1'b0;
        rst0 = 1'b0;

        // Directed vectors; the model follows along so later traffic stays consistent.
        foreach (vecs[i]) begin
            model_access(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, m_rd, m_er);
            txn(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, vecs[i].hold,
                vecs[i].exp_rd, vecs[i].exp_er);
        end

        // Fill words 0..63 so random reads always see defined data.
        for (int i = 0; i < 64; i++) begin
            a = BASE + 32'(4 * i);
            d = $urandom;
            model_access(a, 1'b1, d, 4'hF, m_rd, m_er);
            txn(a, 1'b1, d, 4'hF, 0, m_rd, m_er);
        end

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE - 32'($urandom_range(1, 64));
            else if (r == 1) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 255));
            else             a = BASE + 32'($urandom_range(0, 255));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            model_access(a, w, d, m, m_rd, m_er);
            txn(a, w, d, m, $urandom_range(0, 3), m_rd, m_er);
        end

        // Reset while in WAIT drops the pending response.
        bus.req_valid  = 1'b1;
        bus.req_addr   = BASE;
        bus.req_wen    = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_in_wait_ready", 32'(bus.req_ready), 32'd0);
        check("abort_in_wait_valid", 32'(bus.resp_valid), 32'd0);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rdata", bus.resp_rdata, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        bus.resp_ready = 1'b0;
        model_access(BASE + 32'h4, 1'b0, 32'h0, 4'h0, m_rd, m_er);
        txn(BASE + 32'h4, 1'b0, 32'h0, 4'h0, 0, m_rd, m_er);

        // Zero-latency instance, req_valid held high: one transaction every 2 cycles.
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check("l0_idle_ready", 32'(bus0.req_ready), 32'd1);
            check("l0_idle_valid", 32'(bus0.resp_valid), 32'd0);
            bus0.req_valid = 1'b1;
            bus0.req_wen   = (i < 4);
            bus0.req_addr  = BASE + 32'(4 * (i % 4));
            bus0.req_wdata = 32'hC0DE_0000 + 32'(i);
            bus0.req_wmask = 4'hF;
            @(posedge clk);
            @(negedge clk);
            check("l0_resp_valid", 32'(bus0.resp_valid), 32'd1);
            check("l0_resp_ready_low", 32'(bus0.req_ready), 32'd0);
            check("l0_resp_rdata", bus0.resp_rdata, (i < 4) ? 32'h0 : 32'hC0DE_0000 + 32'(i - 4));
            check("l0_resp_err", 32'(bus0.resp_err), 32'd0);
            bus0.req_addr  = $urandom;
            bus0.req_wen   = 1'b1;
            bus0.req_wdata = $urandom;
            @(posedge clk);
            @(negedge clk);
        end
        bus0.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("l0_end_idle", 32'(bus0.resp_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
